// File: rtl/clk2_monitor.sv
// Checker for the divided clock clk2: edge ticks, run-length measurement,
// duty-pattern check, period counting, and lock/error status.
module clk2_monitor #(
  parameter int unsigned EXP_HIGH     = 2,
  parameter int unsigned EXP_LOW      = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk2,
  input  logic             err_clr,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] last_high,
  output logic [CNT_W-1:0] last_low
);

  localparam int unsigned STREAK_W = $clog2(LOCK_PERIODS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

  state_t              state;
  logic                c2_q;
  logic [CNT_W-1:0]    run_cnt;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic                run_bad;
  logic                period_bad;
  logic                rise;
  logic                fall;
  logic                err_high;
  logic                err_low;
  logic                err_now;

  assign rise = clk2 & ~c2_q;
  assign fall = ~clk2 & c2_q;

  // A run is bad if it ends short, or once when it is about to overrun.
  assign err_high = (state == HIGH) &&
                    (fall ? (run_cnt < CNT_W'(EXP_HIGH))
                          : ((run_cnt == CNT_W'(EXP_HIGH)) && !run_bad));
  assign err_low  = (state == LOW) &&
                    (rise ? (run_cnt < CNT_W'(EXP_LOW))
                          : ((run_cnt == CNT_W'(EXP_LOW)) && !run_bad));
  assign err_now  = en && (err_high || err_low);

  always_comb begin
    streak_nxt = streak;
    if (!en || err_now) begin
      streak_nxt = '0;
    end else if ((state == LOW) && rise) begin
      if (period_bad)
        streak_nxt = '0;
      else if (streak != STREAK_W'(LOCK_PERIODS))
        streak_nxt = streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      c2_q       <= 1'b0;
      run_cnt    <= CNT_W'(1);
      streak     <= '0;
      run_bad    <= 1'b0;
      period_bad <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      period_cnt <= '0;
      last_high  <= '0;
      last_low   <= '0;
    end else begin
      c2_q       <= clk2;
      run_cnt    <= (rise || fall) ? CNT_W'(1)
                  : ((run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_W'(1));
      rise_tick  <= en && (state != IDLE) && rise;
      fall_tick  <= en && (state != IDLE) && fall;
      err_pulse  <= err_now;
      err_sticky <= err_now || (err_sticky && !err_clr);
      streak     <= streak_nxt;
      locked     <= (streak_nxt == STREAK_W'(LOCK_PERIODS));

      if (!en) begin
        state      <= IDLE;
        run_bad    <= 1'b0;
        period_bad <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          // Runs before the first rise are partial and never checked.
          SYNC: if (rise) begin
            state      <= HIGH;
            run_bad    <= 1'b0;
            period_bad <= 1'b0;
          end
          HIGH: if (fall) begin
            last_high  <= run_cnt;
            run_bad    <= 1'b0;
            period_bad <= period_bad || err_now;
            state      <= LOW;
          end else if (err_now) begin
            run_bad    <= 1'b1;
            period_bad <= 1'b1;
          end
          LOW: if (rise) begin
            last_low   <= run_cnt;
            period_cnt <= period_cnt + CNT_W'(1);
            run_bad    <= 1'b0;
            period_bad <= 1'b0;
            state      <= HIGH;
          end else if (err_now) begin
            run_bad    <= 1'b1;
            period_bad <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
